// File: rtl/bcd_add_datapath_if.sv
// Request/ack command bus between the BCD add controller (master) and its datapath (slave).
// Also carries the switch operand input, the display register and the sticky error flag.
interface bcd_add_datapath_if #(
  parameter int unsigned Digits = 2
) ();
  localparam int unsigned W = 4 * Digits;

  logic         bcd_init;
  logic         bcd_init_ack;
  logic         bcd_load_a;
  logic         bcd_load_a_ack;
  logic         bcd_load_b;
  logic         bcd_load_b_ack;
  logic         bcd_display_a;
  logic         bcd_display_a_ack;
  logic         bcd_display_b;
  logic         bcd_display_b_ack;
  logic         bcd_add;
  logic         bcd_add_ack;
  logic         bcd_display_result_ls;
  logic         bcd_display_result_ls_ack;
  logic         bcd_display_result_ms;
  logic         bcd_display_result_ms_ack;
  logic [W-1:0] sw;
  logic [W-1:0] disp;
  logic         bcd_err;

  modport master (
    output bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b, bcd_add,
           bcd_display_result_ls, bcd_display_result_ms, sw,
    input  bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack, bcd_display_b_ack,
           bcd_add_ack, bcd_display_result_ls_ack, bcd_display_result_ms_ack, disp, bcd_err
  );

  modport slave (
    input  bcd_init, bcd_load_a, bcd_load_b, bcd_display_a, bcd_display_b, bcd_add,
           bcd_display_result_ls, bcd_display_result_ms, sw,
    output bcd_init_ack, bcd_load_a_ack, bcd_load_b_ack, bcd_display_a_ack, bcd_display_b_ack,
           bcd_add_ack, bcd_display_result_ls_ack, bcd_display_result_ms_ack, disp, bcd_err
  );
endinterface

// File: rtl/bcd_add_datapath.sv
// BCD add datapath: operand registers, digit-serial packed-BCD adder with decimal correction,
// and display register, driven by a 4-phase request/ack command set.
module bcd_add_datapath #(
  parameter int unsigned Digits = 2
) (
  input logic              clk,
  input logic              rst,
  bcd_add_datapath_if.slave bus
);
  localparam int unsigned W    = 4 * Digits;
  localparam int unsigned IdxW = (Digits > 1) ? $clog2(Digits) : 1;

  // Request/ack vector bit positions; lower index wins arbitration.
  localparam logic [2:0] OpInit  = 3'd0;
  localparam logic [2:0] OpLoadA = 3'd1;
  localparam logic [2:0] OpLoadB = 3'd2;
  localparam logic [2:0] OpAdd   = 3'd3;
  localparam logic [2:0] OpDispA = 3'd4;
  localparam logic [2:0] OpDispB = 3'd5;
  localparam logic [2:0] OpResLs = 3'd6;
  localparam logic [2:0] OpResMs = 3'd7;

  typedef enum logic [1:0] {StIdle, StAddRun, StAckHold} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, disp_q, disp_d;
  logic            carry_q, carry_d, err_q, err_d, c_q, c_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      ack_q, ack_d;

  logic [7:0]      req;
  logic [7:0]      grant;
  logic [2:0]      grant_idx;
  logic [3:0]      a_dig, b_dig, d_dig;
  logic [4:0]      s_dig;
  logic            c_out;

  assign req = {bus.bcd_display_result_ms, bus.bcd_display_result_ls, bus.bcd_display_b,
                bus.bcd_display_a, bus.bcd_add, bus.bcd_load_b, bus.bcd_load_a, bus.bcd_init};

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < int'(Digits); k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Scan from the lowest-priority bit up so the highest-priority request is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (req[k]) begin
        grant     = 8'(1) << k;
        grant_idx = 3'(k);
      end
    end
  end

  always_comb begin
    a_dig = a_q[int'(idx_q)*4 +: 4];
    b_dig = b_q[int'(idx_q)*4 +: 4];
    s_dig = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c_q};
    if (s_dig > 5'd9) begin
      c_out = 1'b1;
      d_dig = s_dig[3:0] + 4'd6;
    end else begin
      c_out = 1'b0;
      d_dig = s_dig[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    disp_d  = disp_q;
    err_d   = err_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    ack_d   = ack_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          sel_d = grant_idx;
          if (grant_idx == OpAdd) begin
            idx_d   = '0;
            c_d     = 1'b0;
            state_d = StAddRun;
          end else begin
            ack_d   = grant;
            state_d = StAckHold;
            unique case (grant_idx)
              OpInit: begin
                a_d     = '0;
                b_d     = '0;
                sum_d   = '0;
                carry_d = 1'b0;
                disp_d  = '0;
                err_d   = 1'b0;
              end
              OpLoadA: begin
                a_d   = bus.sw;
                err_d = err_q | has_bad_digit(bus.sw);
              end
              OpLoadB: begin
                b_d   = bus.sw;
                err_d = err_q | has_bad_digit(bus.sw);
              end
              OpDispA: disp_d = a_q;
              OpDispB: disp_d = b_q;
              OpResLs: disp_d = sum_q;
              OpResMs: disp_d = W'(carry_q);
              default: ;
            endcase
          end
        end
      end
      StAddRun: begin
        sum_d[int'(idx_q)*4 +: 4] = d_dig;
        c_d   = c_out;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(Digits - 1)) begin
          carry_d = c_out;
          ack_d   = 8'(1) << OpAdd;
          state_d = StAckHold;
        end
      end
      StAckHold: begin
        // A request already dropped during the add makes the ack a one-cycle pulse.
        if (!req[sel_q]) begin
          ack_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.bcd_init_ack              = ack_q[OpInit];
  assign bus.bcd_load_a_ack            = ack_q[OpLoadA];
  assign bus.bcd_load_b_ack            = ack_q[OpLoadB];
  assign bus.bcd_add_ack               = ack_q[OpAdd];
  assign bus.bcd_display_a_ack         = ack_q[OpDispA];
  assign bus.bcd_display_b_ack         = ack_q[OpDispB];
  assign bus.bcd_display_result_ls_ack = ack_q[OpResLs];
  assign bus.bcd_display_result_ms_ack = ack_q[OpResMs];
  assign bus.disp                      = disp_q;
  assign bus.bcd_err                   = err_q;
endmodule

// File: tb/tb_bcd_add_datapath.sv
// Directed bench for bcd_add_datapath: reference model plus a queue of expected display values
// pushed when each command is issued and popped when its ack arrives.
module tb_bcd_add_datapath;
  localparam int OpInit  = 0;
  localparam int OpLoadA = 1;
  localparam int OpLoadB = 2;
  localparam int OpAdd   = 3;
  localparam int OpDispA = 4;
  localparam int OpDispB = 5;
  localparam int OpResLs = 6;
  localparam int OpResMs = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ma, mb, msum, mdisp;
  logic       mcarry, merr;
  logic [7:0] exp_q[$];
  logic [7:0] ack_vec;

  bcd_add_datapath_if #(.Digits(2)) bus ();

  bcd_add_datapath #(.Digits(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign ack_vec = {bus.bcd_display_result_ms_ack, bus.bcd_display_result_ls_ack,
                    bus.bcd_display_b_ack, bus.bcd_display_a_ack, bus.bcd_add_ack,
                    bus.bcd_load_b_ack, bus.bcd_load_a_ack, bus.bcd_init_ack};

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input logic [7:0] r);
    bus.bcd_init              = r[0];
    bus.bcd_load_a            = r[1];
    bus.bcd_load_b            = r[2];
    bus.bcd_add               = r[3];
    bus.bcd_display_a         = r[4];
    bus.bcd_display_b         = r[5];
    bus.bcd_display_result_ls = r[6];
    bus.bcd_display_result_ms = r[7];
  endtask

  function automatic logic bad(input logic [7:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9);
  endfunction

  task automatic model_reset();
    ma = '0; mb = '0; msum = '0; mcarry = 1'b0; mdisp = '0; merr = 1'b0;
  endtask

  // Decimal add digit by digit: a digit sum above 9 is corrected by +6 and carries.
  task automatic model_add();
    logic [4:0] s;
    logic       c;
    logic [7:0] r;
    c = 1'b0;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      s = 5'(ma[4*k +: 4]) + 5'(mb[4*k +: 4]) + 5'(c);
      if (s > 5'd9) begin
        c = 1'b1;
        s = s + 5'd6;
      end else begin
        c = 1'b0;
      end
      r[4*k +: 4] = s[3:0];
    end
    msum   = r;
    mcarry = c;
  endtask

  task automatic model_apply(input int op, input logic [7:0] swv);
    case (op)
      OpInit:  model_reset();
      OpLoadA: begin ma = swv; merr = merr | bad(swv); end
      OpLoadB: begin mb = swv; merr = merr | bad(swv); end
      OpAdd:   model_add();
      OpDispA: mdisp = ma;
      OpDispB: mdisp = mb;
      OpResLs: mdisp = msum;
      OpResMs: mdisp = {7'b0, mcarry};
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input int op, input logic [7:0] swv, input int lat);
    int cnt;
    bus.sw = swv;
    model_apply(op, swv);
    exp_q.push_back(mdisp);
    set_req(8'(1) << op);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (ack_vec == 8'h00 && cnt < 20);
    check({tag, "_latency"}, 32'(cnt), 32'(lat));
    check({tag, "_ack"}, 32'(ack_vec), 32'(8'(1) << op));
    check({tag, "_disp"}, 32'(bus.disp), 32'(exp_q.pop_front()));
    check({tag, "_err"}, 32'(bus.bcd_err), 32'(merr));
    @(negedge clk);
    check({tag, "_hold"}, 32'(ack_vec), 32'(8'(1) << op));
    set_req(8'h00);
    @(negedge clk);
    check({tag, "_drop"}, 32'(ack_vec), 32'h0);
  endtask

  initial begin
    set_req(8'h00);
    bus.sw = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_disp", 32'(bus.disp), 32'h0);
    check("rst_err", 32'(bus.bcd_err), 32'h0);
    check("rst_acks", 32'(ack_vec), 32'h0);

    do_op("init", OpInit, 8'h00, 1);

    do_op("load_a45", OpLoadA, 8'h45, 1);
    do_op("load_b37", OpLoadB, 8'h37, 1);
    do_op("add45_37", OpAdd, 8'h00, 3);
    do_op("ls45_37", OpResLs, 8'h00, 1);
    do_op("ms45_37", OpResMs, 8'h00, 1);

    do_op("load_a99", OpLoadA, 8'h99, 1);
    do_op("load_b99", OpLoadB, 8'h99, 1);
    do_op("add99_99", OpAdd, 8'h00, 3);
    do_op("ls99_99", OpResLs, 8'h00, 1);
    do_op("ms99_99", OpResMs, 8'h00, 1);
    do_op("disp_a99", OpDispA, 8'h00, 1);

    do_op("load_a3c", OpLoadA, 8'h3C, 1);
    do_op("load_b12", OpLoadB, 8'h12, 1);
    do_op("add3c_12", OpAdd, 8'h00, 3);
    do_op("ls3c_12", OpResLs, 8'h00, 1);
    do_op("init_clr", OpInit, 8'h00, 1);

    // Simultaneous LOAD_A and DISPLAY_B: LOAD_A first, DISPLAY_B once the handshake completes.
    do_op("load_b66", OpLoadB, 8'h66, 1);
    bus.sw = 8'h21;
    model_apply(OpLoadA, 8'h21);
    exp_q.push_back(mdisp);
    set_req((8'(1) << OpLoadA) | (8'(1) << OpDispB));
    @(negedge clk);
    check("prio_ack", 32'(ack_vec), 32'(8'(1) << OpLoadA));
    check("prio_disp", 32'(bus.disp), 32'(exp_q.pop_front()));
    set_req(8'(1) << OpDispB);
    @(negedge clk);
    check("prio_gap", 32'(ack_vec), 32'h0);
    model_apply(OpDispB, 8'h00);
    exp_q.push_back(mdisp);
    @(negedge clk);
    check("prio_second_ack", 32'(ack_vec), 32'(8'(1) << OpDispB));
    check("prio_second_disp", 32'(bus.disp), 32'(exp_q.pop_front()));
    set_req(8'h00);
    @(negedge clk);
    check("prio_drop", 32'(ack_vec), 32'h0);

    // Request withdrawn during the add: the add completes and the ack pulses once.
    do_op("load_a58", OpLoadA, 8'h58, 1);
    do_op("load_b67", OpLoadB, 8'h67, 1);
    model_apply(OpAdd, 8'h00);
    set_req(8'(1) << OpAdd);
    @(negedge clk);
    set_req(8'h00);
    @(negedge clk);
    check("pulse_pre", 32'(ack_vec), 32'h0);
    @(negedge clk);
    check("pulse_on", 32'(ack_vec), 32'(8'(1) << OpAdd));
    @(negedge clk);
    check("pulse_off", 32'(ack_vec), 32'h0);
    do_op("ls58_67", OpResLs, 8'h00, 1);
    do_op("ms58_67", OpResMs, 8'h00, 1);

    // Reset in the middle of an add.
    do_op("load_a11", OpLoadA, 8'h11, 1);
    do_op("load_b22", OpLoadB, 8'h22, 1);
    set_req(8'(1) << OpAdd);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(8'h00);
    @(negedge clk);
    model_reset();
    check("midrst_acks", 32'(ack_vec), 32'h0);
    check("midrst_disp", 32'(bus.disp), 32'h0);
    check("midrst_err", 32'(bus.bcd_err), 32'h0);
    rst = 1'b0;
    do_op("midrst_sum", OpResLs, 8'h00, 1);
    do_op("load_a27", OpLoadA, 8'h27, 1);
    do_op("load_b15", OpLoadB, 8'h15, 1);
    do_op("add27_15", OpAdd, 8'h00, 3);
    do_op("ls27_15", OpResLs, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
